// File: rtl/vga_scan_counter.sv
// vga_scan_counter: divides clk to the pixel rate and walks col/row over the full raster.
// Optional completed-frame counter (frame_cnt port) is built when VGA_FRAME_COUNTER_EN is defined.
module vga_scan_counter #(
   parameter int CLK_DIV   = 2,
   parameter int H_TOTAL   = 800,
   parameter int V_TOTAL   = 525,
   parameter int H_VISIBLE = 640,
   parameter int V_VISIBLE = 480,
   parameter int FRAME_W   = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               en,
   output logic [9:0]         row,
   output logic [9:0]         col,
   output logic               pix_en,
   output logic               active,
   output logic               line_end,
   output logic               frame_end
`ifdef VGA_FRAME_COUNTER_EN
   ,
   output logic [FRAME_W-1:0] frame_cnt
`endif
);

   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [9:0]       COL_LAST = 10'(H_TOTAL - 1);
   localparam logic [9:0]       ROW_LAST = 10'(V_TOTAL - 1);
   localparam logic [10:0]      H_VIS    = 11'(H_VISIBLE);
   localparam logic [10:0]      V_VIS    = 11'(V_VISIBLE);

   generate
      if ((CLK_DIV < 1) || (H_VISIBLE > H_TOTAL) || (V_VISIBLE > V_TOTAL) ||
          (H_TOTAL > 1024) || (V_TOTAL > 1024) || (H_TOTAL < 1) || (V_TOTAL < 1)) begin : g_bad_params
         $error("vga_scan_counter: illegal parameter combination");
      end
   endgenerate

   logic [DIV_W-1:0] div_cnt_r;
   logic [DIV_W-1:0] div_cnt_nxt_s;
   logic [9:0]       col_r;
   logic [9:0]       row_r;
   logic [9:0]       col_nxt_s;
   logic [9:0]       row_nxt_s;
   logic             div_last_s;
   logic             col_last_s;
   logic             row_last_s;
   logic             pix_en_s;
   logic             line_end_s;
   logic             frame_end_s;
   logic             active_s;

   // Strobe and window decode; strobes are forced low while reset is held, even with CLK_DIV=1.
   always_comb begin
      div_last_s = (div_cnt_r == DIV_LAST);
      col_last_s = (col_r == COL_LAST);
      row_last_s = (row_r == ROW_LAST);
      if (en && !reset) begin
         pix_en_s = div_last_s;
      end else begin
         pix_en_s = 1'b0;
      end
      line_end_s  = pix_en_s && col_last_s;
      frame_end_s = line_end_s && row_last_s;
      active_s    = ({1'b0, col_r} < H_VIS) && ({1'b0, row_r} < V_VIS);
   end

   // Next-state for divider and raster position
   always_comb begin
      div_cnt_nxt_s = div_cnt_r;
      col_nxt_s     = col_r;
      row_nxt_s     = row_r;
      if (en) begin
         if (div_last_s) begin
            div_cnt_nxt_s = {DIV_W{1'b0}};
         end else begin
            div_cnt_nxt_s = div_cnt_r + DIV_W'(1);
         end
      end else begin
         div_cnt_nxt_s = div_cnt_r;
      end
      if (pix_en_s) begin
         if (col_last_s) begin
            col_nxt_s = 10'd0;
            if (row_last_s) begin
               row_nxt_s = 10'd0;
            end else begin
               row_nxt_s = row_r + 10'd1;
            end
         end else begin
            col_nxt_s = col_r + 10'd1;
            row_nxt_s = row_r;
         end
      end else begin
         col_nxt_s = col_r;
         row_nxt_s = row_r;
      end
   end

   // State registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         div_cnt_r <= {DIV_W{1'b0}};
         col_r     <= 10'd0;
         row_r     <= 10'd0;
      end else begin
         div_cnt_r <= div_cnt_nxt_s;
         col_r     <= col_nxt_s;
         row_r     <= row_nxt_s;
      end
   end

`ifdef VGA_FRAME_COUNTER_EN
   logic [FRAME_W-1:0] frame_cnt_r;

   // Completed-frame counter, wraps naturally at 2^FRAME_W
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         frame_cnt_r <= {FRAME_W{1'b0}};
      end else if (frame_end_s) begin
         frame_cnt_r <= frame_cnt_r + FRAME_W'(1);
      end else begin
         frame_cnt_r <= frame_cnt_r;
      end
   end

   assign frame_cnt = frame_cnt_r;
`endif

   assign row       = row_r;
   assign col       = col_r;
   assign pix_en    = pix_en_s;
   assign active    = active_s;
   assign line_end  = line_end_s;
   assign frame_end = frame_end_s;

endmodule

// File: tb/tb_vga_scan_counter.sv
// Directed bench for vga_scan_counter: full-size instance for line/freeze timing, a shrunken
// raster instance for frame wrap and window checks, and a CLK_DIV=1 instance.
module tb_vga_scan_counter;

   logic       clk = 1'b0;
   logic       reset;
   logic       en_a, en_b, en_c;
   logic [9:0] a_row, a_col, s_row, s_col, c_row, c_col;
   logic       a_pix, a_act, a_le, a_fe;
   logic       s_pix, s_act, s_le, s_fe;
   logic       c_pix, c_act, c_le, c_fe;
`ifdef VGA_FRAME_COUNTER_EN
   logic [7:0] a_fcnt;
   logic [1:0] s_fcnt;
   logic [7:0] c_fcnt;
`endif

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   vga_scan_counter u_dut (
      .clk(clk), .reset(reset), .en(en_a), .row(a_row), .col(a_col),
      .pix_en(a_pix), .active(a_act), .line_end(a_le), .frame_end(a_fe)
`ifdef VGA_FRAME_COUNTER_EN
      , .frame_cnt(a_fcnt)
`endif
   );

   vga_scan_counter #(.CLK_DIV(2), .H_TOTAL(8), .V_TOTAL(5), .H_VISIBLE(6), .V_VISIBLE(4), .FRAME_W(2)) u_small (
      .clk(clk), .reset(reset), .en(en_b), .row(s_row), .col(s_col),
      .pix_en(s_pix), .active(s_act), .line_end(s_le), .frame_end(s_fe)
`ifdef VGA_FRAME_COUNTER_EN
      , .frame_cnt(s_fcnt)
`endif
   );

   vga_scan_counter #(.CLK_DIV(1), .H_TOTAL(8), .V_TOTAL(5), .H_VISIBLE(6), .V_VISIBLE(4)) u_div1 (
      .clk(clk), .reset(reset), .en(en_c), .row(c_row), .col(c_col),
      .pix_en(c_pix), .active(c_act), .line_end(c_le), .frame_end(c_fe)
`ifdef VGA_FRAME_COUNTER_EN
      , .frame_cnt(c_fcnt)
`endif
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Reference for the 8x5, CLK_DIV=2 instance, n clk edges after enable
   task automatic check_small(input int n);
      int d, p, c, r;
      d = n % 2;
      p = n / 2;
      c = p % 8;
      r = (p / 8) % 5;
      check("s_col", s_col, c);
      check("s_row", s_row, r);
      check("s_pix_en", s_pix, (d == 1));
      check("s_line_end", s_le, (d == 1) && (c == 7));
      check("s_frame_end", s_fe, (d == 1) && (c == 7) && (r == 4));
      check("s_active", s_act, (c < 6) && (r < 4));
`ifdef VGA_FRAME_COUNTER_EN
      check("s_frame_cnt", s_fcnt, (p / 40) % 4);
`endif
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int le_cnt, le_col, pix_cnt, last_pix, fe_cnt, last_fe;
      logic [9:0] held;

      // Reset state, including strobe gating on the CLK_DIV=1 instance
      reset = 1'b1; en_a = 1'b0; en_b = 1'b0; en_c = 1'b1;
      #10;
      check("rst_row", a_row, 0);
      check("rst_col", a_col, 0);
      check("rst_pix_en", a_pix, 0);
      check("rst_line_end", a_le, 0);
      check("rst_frame_end", a_fe, 0);
      check("rst_active", a_act, 1);
      check("rst_div1_pix_en", c_pix, 0);

      #17;
      reset = 1'b0;
      en_a  = 1'b1;
      #1;
      check("rel_pix_en", a_pix, 0);
      check("rel_col", a_col, 0);
      check("rel_div1_pix_en", c_pix, 1);
      check("rel_div1_col", c_col, 0);
      step();
      check("first_pix_en", a_pix, 1);
      check("first_pix_col", a_col, 0);
      check("div1_col_1", c_col, 1);
      step();
      check("after_pix_col", a_col, 1);
      check("after_pix_en", a_pix, 0);
      check("div1_col_2", c_col, 2);

      // One full line: pix_en every 2 clk, single line_end at col 799
      le_cnt = 0; le_col = -1; pix_cnt = 0; last_pix = -1;
      for (int k = 1; k <= 1598; k++) begin
         step();
         check("div1_pix_every_cycle", c_pix, 1);
         if (a_pix) begin
            if (last_pix >= 0) check("pix_period", k - last_pix, 2);
            last_pix = k;
            pix_cnt++;
         end
         if (a_le) begin
            le_cnt++;
            le_col = a_col;
         end
         check("line_no_frame_end", a_fe, 0);
      end
      check("line_end_count", le_cnt, 1);
      check("line_end_col", le_col, 799);
      check("line_pix_count", pix_cnt, 799);
      check("next_row", a_row, 1);
      check("next_col", a_col, 0);

      // Freeze mid-pixel at col 100
      for (int k = 0; k < 201; k++) step();
      check("pre_freeze_col", a_col, 100);
      check("pre_freeze_row", a_row, 1);
      check("pre_freeze_pix", a_pix, 1);
      check("pre_freeze_active", a_act, 1);
      en_a = 1'b0;
      #1;
      check("freeze_pix_now", a_pix, 0);
      for (int k = 0; k < 10; k++) begin
         step();
         check("freeze_col", a_col, 100);
         check("freeze_row", a_row, 1);
         check("freeze_pix", a_pix, 0);
      end
      en_a = 1'b1;
      #1;
      check("resume_pix", a_pix, 1);
      check("resume_col", a_col, 100);
      step();
      check("resume_col_101", a_col, 101);
      check("resume_pix_0", a_pix, 0);
      step();
      check("resume_pix_1", a_pix, 1);
      check("resume_col_101b", a_col, 101);
      step();
      check("resume_col_102", a_col, 102);

      // CLK_DIV=1 instance: en low removes pix_en and holds col
      en_c = 1'b0;
      #1;
      check("div1_en0_pix", c_pix, 0);
      held = c_col;
      step();
      check("div1_en0_hold", c_col, held);

      // Shrunken raster: four frames, wrap, window edges, frame counter
      en_b = 1'b1;
      #1;
      fe_cnt = 0; last_fe = -1;
      for (int n = 0; n <= 320; n++) begin
         check_small(n);
         if (s_fe) begin
            if (last_fe >= 0) check("frame_len", n - last_fe, 80);
            last_fe = n;
            fe_cnt++;
         end
         if (n < 320) step();
      end
      check("frame_end_count", fe_cnt, 4);
      for (int n = 321; n <= 370; n++) begin
         step();
         check_small(n);
      end
      check("pre_reset_row", s_row, 3);

      // Asynchronous reset away from any clk edge
      #2;
      reset = 1'b1;
      #1;
      check("async_rst_row", s_row, 0);
      check("async_rst_col", s_col, 0);
      check("async_rst_a_row", a_row, 0);
      check("async_rst_a_col", a_col, 0);
      check("async_rst_pix", s_pix, 0);
`ifdef VGA_FRAME_COUNTER_EN
      check("async_rst_fcnt", s_fcnt, 0);
`endif
      #3;
      reset = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
